// File: rtl/sound_turn_ctrl.sv
// sound_turn_ctrl: qualifies the direction-finder code, fires one timed motor
// turn per accepted event, then cools down before re-arming the finder.
module sound_turn_ctrl #(
  parameter int unsigned STABLE_CYCLES   = 1000,
  parameter int unsigned TURN_CYCLES     = 25_000_000,
  parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] direction,
  output logic       find_enable,
  output logic       turn_left,
  output logic       turn_right,
  output logic       busy,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LISTEN  = 3'd1,
    S_QUALIFY = 3'd2,
    S_TURN    = 3'd3,
    S_COOL    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TURN_N   = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] COOL_N   = CNT_W'(COOLDOWN_CYCLES);

  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic [7:0]       ev_q, ev_d;
  logic             find_q, find_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic             busy_q, busy_d;

  // Next-state, shared counter and registered-output computation.
  // The counter is the number of matching samples in QUALIFY and the number of
  // elapsed cycles in TURN/COOLDOWN. A direction is accepted once the count
  // reaches STABLE_CYCLES; TURN is entered on the following edge, so the motor
  // output rises STABLE_CYCLES edges after the first sample was taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    ev_d    = ev_q;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_LISTEN;
          cnt_d   = '0;
        end
        S_LISTEN: begin
          if (direction == DIR_RIGHT || direction == DIR_LEFT) begin
            state_d = S_QUALIFY;
            cand_d  = direction;
            cnt_d   = ONE;
          end
        end
        S_QUALIFY: begin
          if (cnt_q == STABLE_N) begin
            state_d = S_TURN;
            cnt_d   = ONE;
            if (ev_q != 8'hFF) ev_d = ev_q + 8'd1;
          end else if (direction == cand_q) begin
            cnt_d = cnt_q + ONE;
          end else begin
            state_d = S_LISTEN;
            cnt_d   = '0;
          end
        end
        S_TURN: begin
          if (cnt_q == TURN_N) begin
            state_d = S_COOL;
            cnt_d   = ONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        S_COOL: begin
          if (cnt_q == COOL_N) begin
            state_d = S_LISTEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs follow the next state so they change on the same edge as the state.
    find_d  = (state_d == S_LISTEN) || (state_d == S_QUALIFY);
    busy_d  = (state_d == S_TURN) || (state_d == S_COOL);
    left_d  = (state_d == S_TURN) && (cand_d == DIR_LEFT);
    right_d = (state_d == S_TURN) && (cand_d == DIR_RIGHT);
  end

  // State, counter and output registers; reset overrides enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      ev_q    <= '0;
      find_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      ev_q    <= ev_d;
      find_q  <= find_d;
      left_q  <= left_d;
      right_q <= right_d;
      busy_q  <= busy_d;
    end
  end

  assign find_enable = find_q;
  assign turn_left   = left_q;
  assign turn_right  = right_q;
  assign busy        = busy_q;
  assign event_count = ev_q;

endmodule
